phy_mdio_ctrl: RTL and testbench

Management controller for the RMII Ethernet PHY on the 50 MHz reference clock domain. Sequences the PHY hardware reset, then serves single-register Clause-22 MDIO read/write requests from the host logic. Generates MDC and drives/samples MDIO through split output/enable/input signals; the top level builds the tristate buffer on the MDIO pin.

---
 rtl/phy_mdio_ctrl_if.sv | 21 ++
 rtl/phy_mdio_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_phy_mdio_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_mdio_ctrl_if.sv
// Host request/response bus of the PHY management controller.
// The host drives the request side; the controller answers with busy/done/read data.
interface phy_mdio_ctrl_if;
   logic        In_Req;
   logic        In_Write;
   logic [4:0]  In_RegAddr;
   logic [15:0] In_WrData;
   logic        Out_Busy;
   logic        Out_Done;
   logic [15:0] Out_RdData;

   modport master (
      output In_Req, In_Write, In_RegAddr, In_WrData,
      input  Out_Busy, Out_Done, Out_RdData
   );

   modport slave (
      input  In_Req, In_Write, In_RegAddr, In_WrData,
      output Out_Busy, Out_Done, Out_RdData
   );
endinterface

// File: rtl/phy_mdio_ctrl.sv
// RMII PHY management: PHY reset sequencing plus Clause-22 MDIO single-register read/write.
// Optional macro PHY_LINK_POLL_EN adds a periodic internal BMSR read that drives Out_Link_Up.
module phy_mdio_ctrl #(
   parameter int         CLK_DIV           = 10,
   parameter int         RESET_CYCLES      = 500000,
   parameter int         POST_RESET_CYCLES = 50000,
   parameter logic [4:0] PHY_ADDR          = 5'd1
`ifdef PHY_LINK_POLL_EN
   ,
   parameter int         POLL_TIMER_BITS   = 20
`endif
) (
   input  logic           In_CLK_50_Ref,
   input  logic           In_Reset,
   phy_mdio_ctrl_if.slave host,
   output logic           Out_PHY_MDC,
   output logic           Out_PHY_MDIO_O,
   output logic           Out_PHY_MDIO_OE,
   input  logic           In_PHY_MDIO_I,
   output logic           Out_PHY_Reset,
   output logic           Out_Link_Up
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {
      RST_HOLD,
      RST_WAIT,
      IDLE,
      PREAMBLE,
      FRAME,
      DONE
   } state_t;

   state_t           r_state;
   logic [31:0]      r_waitCnt;
   logic [DIV_W-1:0] r_divCnt;
   logic [5:0]       r_bitCnt;
   logic [31:0]      r_shift;
   logic [15:0]      r_rdShift;
   logic [15:0]      r_rdData;
   logic             r_isRead;
   logic             r_phyReset;
   logic             r_mdc;
   logic             r_mdioO;
   logic             r_mdioOe;
   logic             r_busy;
   logic             r_done;

   logic             w_start;
   logic             w_startWrite;
   logic [4:0]       w_startReg;
   logic [15:0]      w_startData;

`ifdef PHY_LINK_POLL_EN
   logic [POLL_TIMER_BITS-1:0] r_pollCnt;
   logic                       r_isInternal;
   logic                       r_linkUp;
   logic                       w_startInternal;
`endif

   // A pending host request always takes priority over an expired poll timer.
   always_comb begin
      w_start      = host.In_Req;
      w_startWrite = host.In_Write;
      w_startReg   = host.In_RegAddr;
      w_startData  = host.In_WrData;
`ifdef PHY_LINK_POLL_EN
      w_startInternal = 1'b0;
      if (!host.In_Req && (r_pollCnt == '1)) begin
         w_start         = 1'b1;
         w_startWrite    = 1'b0;
         w_startReg      = 5'd1;
         w_startInternal = 1'b1;
      end
`endif
   end

   always_ff @(posedge In_CLK_50_Ref) begin
      if (In_Reset) begin
         r_state    <= RST_HOLD;
         r_waitCnt  <= '0;
         r_divCnt   <= '0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_rdShift  <= '0;
         r_rdData   <= '0;
         r_isRead   <= 1'b0;
         r_phyReset <= 1'b0;
         r_mdc      <= 1'b0;
         r_mdioO    <= 1'b1;
         r_mdioOe   <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
`ifdef PHY_LINK_POLL_EN
         r_pollCnt    <= '0;
         r_isInternal <= 1'b0;
         r_linkUp     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            RST_HOLD: begin
               if (r_waitCnt == 32'(RESET_CYCLES - 1)) begin
                  r_state    <= RST_WAIT;
                  r_phyReset <= 1'b1;
                  r_waitCnt  <= '0;
               end else begin
                  r_waitCnt <= r_waitCnt + 32'd1;
               end
            end
            RST_WAIT: begin
               if (r_waitCnt == 32'(POST_RESET_CYCLES - 1)) begin
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
                  r_waitCnt <= '0;
               end else begin
                  r_waitCnt <= r_waitCnt + 32'd1;
               end
            end
            IDLE: begin
               // Loading DIV_LAST makes the first PREAMBLE cycle a bit boundary.
               if (w_start) begin
                  r_state  <= PREAMBLE;
                  r_busy   <= 1'b1;
                  r_isRead <= !w_startWrite;
                  r_shift  <= {2'b01, (w_startWrite ? 2'b01 : 2'b10), PHY_ADDR,
                               w_startReg, 2'b10, w_startData};
                  r_bitCnt <= '0;
                  r_divCnt <= DIV_LAST;
`ifdef PHY_LINK_POLL_EN
                  r_isInternal <= w_startInternal;
                  r_pollCnt    <= '0;
               end else begin
                  r_pollCnt <= r_pollCnt + 1'b1;
`endif
               end
            end
            PREAMBLE, FRAME: begin
               if (r_divCnt == DIV_HALF) begin
                  r_mdc    <= 1'b1;
                  r_divCnt <= r_divCnt + 1'b1;
                  if ((r_state == FRAME) && (r_bitCnt > 6'd16)) begin
                     r_rdShift <= {r_rdShift[14:0], In_PHY_MDIO_I};
                  end
               end else if (r_divCnt == DIV_LAST) begin
                  r_mdc    <= 1'b0;
                  r_divCnt <= '0;
                  if ((r_state == FRAME) && (r_bitCnt == 6'd32)) begin
                     r_state  <= DONE;
                     r_mdioO  <= 1'b1;
                     r_mdioOe <= 1'b0;
`ifdef PHY_LINK_POLL_EN
                     if (r_isInternal) begin
                        r_linkUp <= r_rdShift[2];
                     end else begin
                        r_done <= 1'b1;
                        if (r_isRead) r_rdData <= r_rdShift;
                     end
`else
                     r_done <= 1'b1;
                     if (r_isRead) r_rdData <= r_rdShift;
`endif
                  end else if (r_bitCnt == 6'd32) begin
                     r_state  <= FRAME;
                     r_mdioO  <= r_shift[31];
                     r_mdioOe <= 1'b1;
                     r_shift  <= {r_shift[30:0], 1'b0};
                     r_bitCnt <= 6'd1;
                  end else if (r_state == PREAMBLE) begin
                     r_mdioO  <= 1'b1;
                     r_mdioOe <= 1'b1;
                     r_bitCnt <= r_bitCnt + 6'd1;
                  end else begin
                     // Reads release the pin from the first turnaround bit on.
                     r_mdioO  <= r_shift[31];
                     r_mdioOe <= !(r_isRead && (r_bitCnt >= 6'd14));
                     r_shift  <= {r_shift[30:0], 1'b0};
                     r_bitCnt <= r_bitCnt + 6'd1;
                  end
               end else begin
                  r_divCnt <= r_divCnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= RST_HOLD;
         endcase
      end
   end

   assign host.Out_Busy   = r_busy;
   assign host.Out_Done   = r_done;
   assign host.Out_RdData = r_rdData;
   assign Out_PHY_MDC     = r_mdc;
   assign Out_PHY_MDIO_O  = r_mdioO;
   assign Out_PHY_MDIO_OE = r_mdioOe;
   assign Out_PHY_Reset   = r_phyReset;
`ifdef PHY_LINK_POLL_EN
   assign Out_Link_Up = r_linkUp;
`else
   assign Out_Link_Up = 1'b0;
`endif

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Self-checking bench for phy_mdio_ctrl with a behavioural PHY model and frame reference.
// Define PHY_LINK_POLL_EN to exercise the link-poll build.
module tb_phy_mdio_ctrl;
   localparam int         CLK_DIV           = 2;
   localparam int         RESET_CYCLES      = 8;
   localparam int         POST_RESET_CYCLES = 4;
   localparam logic [4:0] PHY_ADDR          = 5'd1;
   localparam int         LAT               = 1 + 64 * 2 * CLK_DIV;
`ifdef PHY_LINK_POLL_EN
   localparam int         POLL_BITS         = 6;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mdc;
   logic        mdioO;
   logic        mdioOe;
   logic        mdioI;
   logic        phyReset;
   logic        linkUp;
   logic [15:0] phyData = 16'h0000;
   int          riseCnt = 0;
   logic        mdcPrev = 1'b0;
   int          checks = 0;
   int          fails = 0;
   logic [15:0] lastRead = 16'h0000;

   phy_mdio_ctrl_if hostIf();

   phy_mdio_ctrl #(
      .CLK_DIV(CLK_DIV),
      .RESET_CYCLES(RESET_CYCLES),
      .POST_RESET_CYCLES(POST_RESET_CYCLES),
      .PHY_ADDR(PHY_ADDR)
`ifdef PHY_LINK_POLL_EN
      ,
      .POLL_TIMER_BITS(POLL_BITS)
`endif
   ) dut (
      .In_CLK_50_Ref(clk),
      .In_Reset(rst),
      .host(hostIf),
      .Out_PHY_MDC(mdc),
      .Out_PHY_MDIO_O(mdioO),
      .Out_PHY_MDIO_OE(mdioOe),
      .In_PHY_MDIO_I(mdioI),
      .Out_PHY_Reset(phyReset),
      .Out_Link_Up(linkUp)
   );

   always #5 clk = ~clk;

   // PHY model: counts MDC rises in a frame and presents data bit n before rise n.
   always @(posedge clk) begin
      if (!hostIf.Out_Busy) riseCnt <= 0;
      else if (mdc && !mdcPrev) riseCnt <= riseCnt + 1;
      mdcPrev <= mdc;
   end

   assign mdioI = (riseCnt >= 48 && riseCnt < 64) ? phyData[4'(63 - riseCnt)] : 1'b1;

   function automatic logic [63:0] refStream(input logic wr, input logic [4:0] ra, input logic [15:0] wd);
      return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR, ra, 2'b10, wd};
   endfunction

   function automatic logic [63:0] refOe(input logic wr);
      logic [63:0] oe;
      for (int i = 0; i < 64; i++) oe[63 - i] = wr || (i < 46);
      return oe;
   endfunction

   task automatic runFrame(input logic wr, input logic [4:0] ra, input logic [15:0] wd,
                           input int pulseAt, output logic [63:0] oBits, output logic [63:0] oeBits,
                           output int rises, output int latency, output int doneCnt,
                           output logic [15:0] rdAtDone);
      logic prev;
      oBits = '0; oeBits = '0; rises = 0; latency = -1; doneCnt = 0; rdAtDone = '0; prev = 1'b0;
      hostIf.In_Req = 1'b1; hostIf.In_Write = wr; hostIf.In_RegAddr = ra; hostIf.In_WrData = wd;
      @(negedge clk);
      for (int k = 0; k <= LAT + 8; k++) begin
         if (hostIf.Out_Done) begin
            doneCnt++;
            if (latency < 0) begin
               latency  = k;
               rdAtDone = hostIf.Out_RdData;
            end
         end
         if (mdc && !prev) begin
            oBits  = {oBits[62:0], mdioO};
            oeBits = {oeBits[62:0], mdioOe};
            rises++;
         end
         prev = mdc;
         if (k == pulseAt) begin
            hostIf.In_Req = 1'b1; hostIf.In_Write = ~wr; hostIf.In_RegAddr = ~ra; hostIf.In_WrData = ~wd;
         end else begin
            hostIf.In_Req = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic measureResetSeq(output int lowCycles, output int busyFall,
                                  output logic mdcSeen, output logic oeSeen, output logic doneSeen);
      logic seenHigh;
      seenHigh = 1'b0; lowCycles = 0; busyFall = -1; mdcSeen = 1'b0; oeSeen = 1'b0; doneSeen = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (!phyReset && !seenHigh) lowCycles++;
         else seenHigh = 1'b1;
         mdcSeen  = mdcSeen | mdc;
         oeSeen   = oeSeen | mdioOe;
         doneSeen = doneSeen | hostIf.Out_Done;
         if (!hostIf.Out_Busy) begin
            busyFall = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int lowC, fallK;
      logic mdcS, oeS, doneS;
      rst = 1'b1;
      hostIf.In_Req = 1'b0; hostIf.In_Write = 1'b0; hostIf.In_RegAddr = '0; hostIf.In_WrData = '0;
      repeat (3) @(negedge clk);
      checks++; if ({phyReset, hostIf.Out_Busy, hostIf.Out_Done, mdc, mdioO, mdioOe, linkUp} !== 7'b0100100) begin
         fails++; $display("[TB] FAIL reset_outputs: got %b expected %b",
            {phyReset, hostIf.Out_Busy, hostIf.Out_Done, mdc, mdioO, mdioOe, linkUp}, 7'b0100100);
      end
      checks++; if (hostIf.Out_RdData !== 16'h0000) begin
         fails++; $display("[TB] FAIL reset_rddata: got %h expected 0000", hostIf.Out_RdData);
      end
      rst = 1'b0;
      measureResetSeq(lowC, fallK, mdcS, oeS, doneS);
      checks++; if (lowC !== RESET_CYCLES) begin
         fails++; $display("[TB] FAIL reset_low_cycles: got %0d expected %0d", lowC, RESET_CYCLES);
      end
      checks++; if (fallK !== RESET_CYCLES + POST_RESET_CYCLES) begin
         fails++; $display("[TB] FAIL reset_busy_fall: got %0d expected %0d", fallK, RESET_CYCLES + POST_RESET_CYCLES);
      end
      checks++; if ({mdcS, oeS, doneS} !== 3'b000) begin
         fails++; $display("[TB] FAIL reset_quiet_pins: got %b expected 000", {mdcS, oeS, doneS});
      end
   endtask

   task automatic test_write();
      logic [63:0] ob, oeb;
      int r, lat, dc;
      logic [15:0] rd;
      runFrame(1'b1, 5'd0, 16'h3100, -1, ob, oeb, r, lat, dc, rd);
      checks++; if (ob !== refStream(1'b1, 5'd0, 16'h3100)) begin
         fails++; $display("[TB] FAIL write_stream: got %h expected %h", ob, refStream(1'b1, 5'd0, 16'h3100));
      end
      checks++; if (oeb !== refOe(1'b1)) begin
         fails++; $display("[TB] FAIL write_oe: got %h expected %h", oeb, refOe(1'b1));
      end
      checks++; if (lat !== LAT || dc !== 1 || r !== 64) begin
         fails++; $display("[TB] FAIL write_timing: got lat=%0d done=%0d rises=%0d expected lat=%0d done=1 rises=64", lat, dc, r, LAT);
      end
   endtask

   task automatic test_read();
      logic [63:0] ob, oeb, m;
      int r, lat, dc;
      logic [15:0] rd;
      phyData = 16'h0022;
      runFrame(1'b0, 5'd2, 16'h0000, -1, ob, oeb, r, lat, dc, rd);
      m = refOe(1'b0);
      checks++; if ((ob & m) !== (refStream(1'b0, 5'd2, 16'h0000) & m)) begin
         fails++; $display("[TB] FAIL read_stream: got %h expected %h", ob & m, refStream(1'b0, 5'd2, 16'h0000) & m);
      end
      checks++; if (oeb !== m) begin
         fails++; $display("[TB] FAIL read_oe: got %h expected %h", oeb, m);
      end
      checks++; if (lat !== LAT || dc !== 1 || rd !== 16'h0022) begin
         fails++; $display("[TB] FAIL read_result: got lat=%0d done=%0d data=%h expected lat=%0d done=1 data=0022", lat, dc, rd, LAT);
      end
      lastRead = 16'h0022;
      runFrame(1'b1, 5'd4, 16'hFFFF, -1, ob, oeb, r, lat, dc, rd);
      checks++; if (hostIf.Out_RdData !== lastRead) begin
         fails++; $display("[TB] FAIL read_hold: got %h expected %h", hostIf.Out_RdData, lastRead);
      end
   endtask

   task automatic test_random();
      logic [63:0] ob, oeb, m;
      int r, lat, dc;
      logic [15:0] rd, wd;
      logic [4:0] ra;
      logic wr;
      for (int t = 0; t < 6; t++) begin
         wr = 1'($urandom_range(0, 1)); ra = 5'($urandom); wd = 16'($urandom); phyData = 16'($urandom);
         runFrame(wr, ra, wd, -1, ob, oeb, r, lat, dc, rd);
         m = refOe(wr);
         if (!wr) lastRead = phyData;
         checks++; if ((ob & m) !== (refStream(wr, ra, wd) & m) || oeb !== m) begin
            fails++; $display("[TB] FAIL random_frame[%0d]: got o=%h oe=%h expected o=%h oe=%h", t, ob & m, oeb, refStream(wr, ra, wd) & m, m);
         end
         checks++; if (lat !== LAT || dc !== 1 || rd !== lastRead) begin
            fails++; $display("[TB] FAIL random_result[%0d]: got lat=%0d done=%0d data=%h expected lat=%0d done=1 data=%h", t, lat, dc, rd, LAT, lastRead);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [63:0] ob, oeb;
      int r, lat, dc;
      logic [15:0] rd;
      runFrame(1'b1, 5'd3, 16'h1234, 100, ob, oeb, r, lat, dc, rd);
      checks++; if (ob !== refStream(1'b1, 5'd3, 16'h1234)) begin
         fails++; $display("[TB] FAIL busy_ignore_stream: got %h expected %h", ob, refStream(1'b1, 5'd3, 16'h1234));
      end
      checks++; if (dc !== 1 || hostIf.Out_Busy !== 1'b0) begin
         fails++; $display("[TB] FAIL busy_ignore_count: got done=%0d busy=%b expected done=1 busy=0", dc, hostIf.Out_Busy);
      end
   endtask

   task automatic test_back_to_back();
      int doneAt[2];
      int nDone, idleCycles;
      doneAt = '{-1, -1}; nDone = 0; idleCycles = 0;
      hostIf.In_Req = 1'b1; hostIf.In_Write = 1'b1; hostIf.In_RegAddr = 5'($urandom); hostIf.In_WrData = 16'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3 * LAT && nDone < 2; k++) begin
         if (nDone == 1 && !hostIf.Out_Busy) idleCycles++;
         if (hostIf.Out_Done) begin
            doneAt[nDone] = k;
            nDone++;
         end
         if (nDone == 2) hostIf.In_Req = 1'b0;
         @(negedge clk);
      end
      hostIf.In_Req = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (nDone !== 2 || doneAt[0] !== LAT || doneAt[1] - doneAt[0] !== LAT + 2) begin
         fails++; $display("[TB] FAIL b2b_timing: got n=%0d first=%0d gap=%0d expected n=2 first=%0d gap=%0d", nDone, doneAt[0], doneAt[1] - doneAt[0], LAT, LAT + 2);
      end
      checks++; if (idleCycles !== 1 || hostIf.Out_Busy !== 1'b0) begin
         fails++; $display("[TB] FAIL b2b_idle: got idle=%0d busy=%b expected idle=1 busy=0", idleCycles, hostIf.Out_Busy);
      end
   endtask

`ifdef PHY_LINK_POLL_EN
   task automatic test_link_poll();
      logic [15:0] bmsr[2];
      logic sawBusy;
      int dc;
      bmsr = '{16'h0004, 16'h0000};
      for (int p = 0; p < 2; p++) begin
         phyData = bmsr[p]; sawBusy = 1'b0; dc = 0;
         for (int k = 0; k < (1 << POLL_BITS) + 20 && !sawBusy; k++) begin
            sawBusy = hostIf.Out_Busy;
            @(negedge clk);
         end
         for (int k = 0; k < LAT + 10 && hostIf.Out_Busy; k++) begin
            if (hostIf.Out_Done) dc++;
            @(negedge clk);
         end
         checks++; if (sawBusy !== 1'b1 || dc !== 0 || linkUp !== bmsr[p][2]) begin
            fails++; $display("[TB] FAIL link_poll[%0d]: got poll=%b done=%0d link=%b expected poll=1 done=0 link=%b", p, sawBusy, dc, linkUp, bmsr[p][2]);
         end
         checks++; if (hostIf.Out_RdData !== lastRead) begin
            fails++; $display("[TB] FAIL link_poll_rddata[%0d]: got %h expected %h", p, hostIf.Out_RdData, lastRead);
         end
      end
   endtask
`else
   task automatic test_link_poll();
      logic sawBusy;
      sawBusy = 1'b0;
      repeat (100) begin
         sawBusy = sawBusy | hostIf.Out_Busy;
         @(negedge clk);
      end
      checks++; if (sawBusy !== 1'b0 || linkUp !== 1'b0) begin
         fails++; $display("[TB] FAIL link_off: got busy=%b link=%b expected busy=0 link=0", sawBusy, linkUp);
      end
   endtask
`endif

   task automatic test_reset_midframe();
      logic [63:0] ob, oeb;
      int r, lat, dc, lowC, fallK, rises;
      logic [15:0] rd;
      logic prev, hit, mdcS, oeS, doneS;
      phyData = 16'($urandom); prev = 1'b0; hit = 1'b0; rises = 0;
      hostIf.In_Req = 1'b1; hostIf.In_Write = 1'b0; hostIf.In_RegAddr = 5'd4;
      @(negedge clk);
      hostIf.In_Req = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         if (mdc && !prev) rises++;
         prev = mdc;
         if (rises == 40) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++; if (hit !== 1'b1) begin
         fails++; $display("[TB] FAIL midframe_reach: got rises=%0d expected 40", rises);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({mdioOe, mdc, phyReset, hostIf.Out_Busy, hostIf.Out_Done} !== 5'b00010 || hostIf.Out_RdData !== 16'h0000) begin
         fails++; $display("[TB] FAIL midframe_abort: got pins=%b rd=%h expected pins=00010 rd=0000",
            {mdioOe, mdc, phyReset, hostIf.Out_Busy, hostIf.Out_Done}, hostIf.Out_RdData);
      end
      @(negedge clk);
      rst = 1'b0;
      lastRead = 16'h0000;
      measureResetSeq(lowC, fallK, mdcS, oeS, doneS);
      checks++; if (lowC !== RESET_CYCLES || fallK !== RESET_CYCLES + POST_RESET_CYCLES || {mdcS, oeS, doneS} !== 3'b000) begin
         fails++; $display("[TB] FAIL midframe_replay: got low=%0d fall=%0d quiet=%b expected low=%0d fall=%0d quiet=000",
            lowC, fallK, {mdcS, oeS, doneS}, RESET_CYCLES, RESET_CYCLES + POST_RESET_CYCLES);
      end
      phyData = 16'h5A5A;
      runFrame(1'b0, 5'd2, 16'h0000, -1, ob, oeb, r, lat, dc, rd);
      lastRead = 16'h5A5A;
      checks++; if (lat !== LAT || dc !== 1 || rd !== 16'h5A5A) begin
         fails++; $display("[TB] FAIL midframe_recover: got lat=%0d done=%0d data=%h expected lat=%0d done=1 data=5a5a", lat, dc, rd, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_link_poll();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
